// File: rtl/rx_pkg.sv
// Shared definitions for the receive beamformer.
//   FSM state codes, Q12.4 rounding constants, sample counter width and
//   the helper that sizes the beamformed output word.
package rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t ACQ    = 3'd1;
  localparam state_t ACCUM  = 3'd2;
  localparam state_t DRAIN  = 3'd3;
  localparam state_t FINISH = 3'd4;

  localparam int SF_SHIFT       = 4;
  localparam int ROUND_HALF     = 8;
  localparam int SAMPLE_CNT_W   = 13;
  localparam int SAMPLE_CNT_MAX = 4096;

  // Sum of NUM_ELEMENTS signed samples cannot exceed this width.
  function automatic int out_width(input int num_elements, input int dw_sample);
    return dw_sample + $clog2(num_elements);
  endfunction

endpackage

// File: rtl/rx_beamformer_if.sv
// Scanline control, sample stream, point handshake and result bus.
//   master: drives initiate/num_points, samples and point delays;
//           observes pt_ready and the result outputs.
//   slave : the beamformer.
interface rx_beamformer_if #(
  parameter int NUM_ELEMENTS = 64,
  parameter int DW_SAMPLE    = 12,
  parameter int DW_DELAY     = 16
) ();
  localparam int DW_OUT = rx_pkg::out_width(NUM_ELEMENTS, DW_SAMPLE);

  logic                                initiate;
  logic [rx_pkg::SAMPLE_CNT_W-1:0]     num_points;
  logic                                sample_valid;
  logic [NUM_ELEMENTS*DW_SAMPLE-1:0]   sample_data;
  logic                                pt_valid;
  logic                                pt_ready;
  logic [NUM_ELEMENTS*DW_DELAY-1:0]    pt_delay;
  logic                                out_valid;
  logic [DW_OUT-1:0]                   out_data;
  logic                                out_stale;
  logic                                done;

  modport master (
    output initiate, num_points, sample_valid, sample_data, pt_valid, pt_delay,
    input  pt_ready, out_valid, out_data, out_stale, done
  );

  modport slave (
    input  initiate, num_points, sample_valid, sample_data, pt_valid, pt_delay,
    output pt_ready, out_valid, out_data, out_stale, done
  );
endinterface

// File: rtl/rx_sample_buffer.sv
// Per-channel circular echo buffers.
//   wr_en/wr_addr/wr_data : one sample for every channel written in parallel
//   rd_ch/rd_addr/rd_data : single registered read (data valid next cycle)
module rx_sample_buffer #(
  parameter int NUM_ELEMENTS = 64,
  parameter int DW_SAMPLE    = 12,
  parameter int BUF_AW       = 8
) (
  input  logic                              clk,
  input  logic                              wr_en,
  input  logic [BUF_AW-1:0]                 wr_addr,
  input  logic [NUM_ELEMENTS*DW_SAMPLE-1:0] wr_data,
  input  logic [$clog2(NUM_ELEMENTS)-1:0]   rd_ch,
  input  logic [BUF_AW-1:0]                 rd_addr,
  output logic [DW_SAMPLE-1:0]              rd_data
);

  logic [DW_SAMPLE-1:0] mem [NUM_ELEMENTS][2**BUF_AW];

  // Read-before-write: a same-address read returns the older sample.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int ch = 0; ch < NUM_ELEMENTS; ch++) begin
        mem[ch][wr_addr] <= wr_data[ch*DW_SAMPLE +: DW_SAMPLE];
      end
    end
    rd_data <= mem[rd_ch][rd_addr];
  end

endmodule

// File: rtl/rx_beamformer.sv
// Delay-and-sum receive beamformer for one scanline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rx_beamformer_if.slave (control, samples, points, results)
//
// state  | meaning
// IDLE   | waiting for initiate
// ACQ    | capturing samples, pt_ready high
// ACCUM  | one element read per cycle, stalls on unwritten samples
// DRAIN  | add last element, publish result
// FINISH | pulse done, return to IDLE
module rx_beamformer
  import rx_pkg::*;
#(
  parameter int NUM_ELEMENTS = 64,
  parameter int DW_SAMPLE    = 12,
  parameter int DW_DELAY     = 16,
  parameter int BUF_AW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  rx_beamformer_if.slave   bus
);

  localparam int DW_OUT = out_width(NUM_ELEMENTS, DW_SAMPLE);
  localparam int EW     = $clog2(NUM_ELEMENTS);
  localparam int CW     = SAMPLE_CNT_W;
  localparam logic [EW-1:0] E_LAST  = EW'(NUM_ELEMENTS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_CNT_MAX);
  localparam logic [CW-1:0] DEPTH   = CW'(2**BUF_AW);

  state_t                         state;
  logic [CW-1:0]                  np, sample_cnt, pt_cnt;
  logic [NUM_ELEMENTS*DW_DELAY-1:0] delay_r;
  logic [EW-1:0]                  e;
  logic [DW_OUT-1:0]              acc, acc_next;
  logic                           stale, rd_pend;
  logic [DW_SAMPLE-1:0]           rd_data;
  logic [DW_DELAY:0]              rounded;
  logic [CW-1:0]                  idx;
  logic                           wr_en, pt_fire, wait_smp, too_old;

  assign wr_en       = (state != IDLE) && bus.sample_valid && (sample_cnt != CNT_MAX);
  assign bus.pt_ready = (state == ACQ);
  assign pt_fire     = bus.pt_valid && (state == ACQ);

  // Round-half-up of the Q12.4 delay to an absolute sample index.
  assign rounded  = {1'b0, delay_r[e*DW_DELAY +: DW_DELAY]} + (DW_DELAY+1)'(ROUND_HALF);
  assign idx      = CW'(rounded >> SF_SHIFT);
  assign wait_smp = (idx >= sample_cnt);
  assign too_old  = ((sample_cnt - idx) > DEPTH);

  // rd_pend marks that rd_data holds the sample issued last cycle.
  assign acc_next = acc + (rd_pend ? {{(DW_OUT-DW_SAMPLE){rd_data[DW_SAMPLE-1]}}, rd_data}
                                   : '0);

  rx_sample_buffer #(
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .DW_SAMPLE    (DW_SAMPLE),
    .BUF_AW       (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (sample_cnt[BUF_AW-1:0]),
    .wr_data (bus.sample_data),
    .rd_ch   (e),
    .rd_addr (idx[BUF_AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      np            <= '0;
      sample_cnt    <= '0;
      pt_cnt        <= '0;
      e             <= '0;
      acc           <= '0;
      stale         <= 1'b0;
      rd_pend       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_stale <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      if (wr_en) sample_cnt <= sample_cnt + CW'(1);

      case (state)
        IDLE: begin
          if (bus.initiate) begin
            np         <= bus.num_points;
            sample_cnt <= '0;
            pt_cnt     <= '0;
            if (bus.num_points == '0) bus.done <= 1'b1;
            else                      state    <= ACQ;
          end
        end
        ACQ: begin
          if (pt_fire) begin
            delay_r <= bus.pt_delay;
            e       <= '0;
            acc     <= '0;
            stale   <= 1'b0;
            rd_pend <= 1'b0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (wait_smp) begin
            rd_pend <= 1'b0;
          end else begin
            rd_pend <= !too_old;
            if (too_old) stale <= 1'b1;
            if (e == E_LAST) state <= DRAIN;
            else             e     <= e + EW'(1);
          end
        end
        DRAIN: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= acc_next;
          bus.out_stale <= stale;
          rd_pend       <= 1'b0;
          pt_cnt        <= pt_cnt + CW'(1);
          state         <= (pt_cnt + CW'(1) == np) ? FINISH : ACQ;
        end
        FINISH: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rx_beamformer.md
Name: rx_beamformer

Overview:
- Receive-side counterpart of the Transmitter: delay-and-sum beamformer for one scanline.
- After `initiate`, it captures echo samples from all NUM_ELEMENTS channels into per-channel circular buffers.
- For each focal point it accepts a per-element delay array in the same fixed-point format as the transmit delayArray (SF = 2^-4). It rounds each delay and sums the addressed samples over all elements, one element per cycle.
- Outputs one beamformed value per point; pulses `done` after num_points values.

Parameters:
- NUM_ELEMENTS, 64, transducer element count
- DW_SAMPLE, 12, signed echo sample width
- DW_DELAY, 16, unsigned delay width (12 integer + 4 fractional bits)
- BUF_AW, 8, log2 of per-channel buffer depth (256 samples)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- initiate  in  1  start of scanline acquisition; 1-cycle pulse
- num_points  in  13  focal points in scanline; latched on initiate
- sample_valid  in  1  one sample per channel present this cycle
- sample_data  in  NUM_ELEMENTS*DW_SAMPLE  channel n at bits [n*DW_SAMPLE +: DW_SAMPLE]
- pt_valid  in  1  delay array for next point valid
- pt_ready  out  1  point accepted when pt_valid & pt_ready
- pt_delay  in  NUM_ELEMENTS*DW_DELAY  per-element delay, Q12.4, absolute sample index from acquisition start
- out_valid  out  1  1-cycle pulse, beamformed value valid
- out_data  out  DW_SAMPLE+$clog2(NUM_ELEMENTS)  signed sum (18 bits at defaults)
- out_stale  out  1  ≥1 element read an overwritten sample; qualified by out_valid
- done  out  1  1-cycle pulse after last point's out_valid

Behaviour:
- Reset: all outputs 0; state IDLE; sample_cnt, pt_cnt and accumulator cleared. Reset mid-operation aborts the scanline. Buffer contents are don't-care.
- IDLE:
  - `initiate` latches num_points, clears sample_cnt and pt_cnt, then goes to ACQ.
  - sample_valid and pt_valid are ignored.
  - num_points = 0 gives a `done` pulse the cycle after initiate, then back to IDLE.
- Sample writes (in every state except IDLE):
  - sample_valid writes each channel at address sample_cnt[BUF_AW-1:0]; sample_cnt (13 bits) increments.
  - At sample_cnt = 4096, further samples are dropped and sample_cnt holds.
- ACQ:
  - pt_ready = 1.
  - On handshake, latch pt_delay; set element e = 0; clear accumulator and stale flag; go to ACCUM.
- ACCUM (one element per cycle):
  - idx_e = (delay_e + 8) >> 4, i.e. round half up.
  - If idx_e ≥ sample_cnt: hold e this cycle (stall until that sample is written).
  - Else if sample_cnt − idx_e > 2^BUF_AW: contribute 0 and set stale.
  - Else: issue a read at idx_e[BUF_AW-1:0].
  - Read data is registered (1 cycle); the sign-extended sample is added to the accumulator one cycle after the read is issued.
  - A write and read of the same address in the same cycle cannot occur, because of the idx_e < sample_cnt rule.
  - After e = NUM_ELEMENTS−1 is issued, go to DRAIN.
- DRAIN: add the final sample. Next cycle: out_valid = 1, with out_data and out_stale. pt_cnt increments.
  - If pt_cnt reaches num_points: `done` the following cycle, then IDLE.
  - Otherwise: ACQ.
- Latency: with no stalls, the point handshake at cycle T gives out_valid at T + NUM_ELEMENTS + 2. Each stall cycle adds 1.
- `initiate` outside IDLE is ignored. pt_ready = 0 in every state except ACQ.
- The accumulator cannot overflow at the declared width. No saturation.

Decomposition:
- Package rx_pkg holds:
  - state enum {IDLE, ACQ, ACCUM, DRAIN, FINISH}
  - SF_SHIFT = 4, ROUND_HALF = 8
  - SAMPLE_CNT_W = 13
  - out_data width function
- One sub-module: rx_sample_buffer. NUM_ELEMENTS × 2^BUF_AW × DW_SAMPLE memory with one parallel write port (all channels) and one registered read port (channel select + address).

Test Plan:
- Ramp, no stall: all channels carry value = sample index mod 256, with 300 samples preloaded. Point with all delays = 16·100 (Q12.4 = 100.0) → out_data = 64·100 = 6400, out_stale = 0, out_valid at T+66.
- Rounding: channel 5 = 1 at sample 10 only, all else 0. delay_5 = 0x0A8 (10.5) → out_data 0 (reads sample 11). delay_5 = 0x0A7 (10.4375) → out_data 1.
- Stall: point handshake with sample_cnt = 50, delay_0 = 16·60 → pt_ready low and no out_valid until sample 60 is written. out_valid exactly 2+63 cycles after sample_cnt becomes 61.
- Stale: 400 samples written, then delay 16·100 on all channels (400−100 > 256) → out_data 0, out_stale = 1.
- Sequence: num_points = 3 with three handshakes → three out_valid pulses, then done one cycle after the third. A second initiate mid-scan is ignored.
- Reset: rst asserted in ACCUM → all outputs 0 next cycle, pt_ready 0. A new initiate restarts with sample_cnt = 0.
